// File: rtl/bus_pkg.sv
// bus_pkg: state encoding, default sizes and index widths
// shared by the bus arbiter and its round-robin picker.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN    = 2'd1,
      LEND   = 2'd2,
      RETURN = 2'd3
   } arb_state_t;

   localparam int N_MASTERS_DEF = 2;
   localparam int N_SLAVES_DEF  = 3;
   localparam int TIMEOUT_DEF   = 64;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int MIDX_W = idx_w(N_MASTERS_DEF);
   localparam int SIDX_W = idx_w(N_SLAVES_DEF);

endpackage

// File: rtl/counter.sv
// counter: up counter with synchronous clear and enable.
// Built only when BUS_ARB_TIMEOUT_EN is defined.
`ifdef BUS_ARB_TIMEOUT_EN
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i)  cnt_q <= cnt_q + 1'b1;
   end

   assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search over masked requests,
// starting at ptr_i and wrapping modulo N.
module rr_pick
   import bus_pkg::*;
#(
   parameter int N = N_MASTERS_DEF,
   parameter int W = idx_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] mask_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         valid_o
);

   logic [N-1:0] elig;
   logic [W-1:0] cand;

   assign elig = req_i & ~mask_i;

   // Walk backwards so the candidate nearest ptr_i is written last.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = W'((int'(ptr_i) + k) % N);
         if (elig[cand]) begin
            idx_o   = cand;
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter with split parking and bus lending.
// Define BUS_ARB_TIMEOUT_EN to bound ownership to TIMEOUT cycles.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter  int N_MASTERS = N_MASTERS_DEF,
   parameter  int N_SLAVES  = N_SLAVES_DEF,
   parameter  int TIMEOUT   = TIMEOUT_DEF,
   localparam int MW        = idx_w(N_MASTERS),
   localparam int SW        = idx_w(N_SLAVES)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_MASTERS-1:0] M_BREQ,
   output logic [N_MASTERS-1:0] M_BGRANT,
   output logic [N_MASTERS-1:0] M_SPLIT,
   output logic [MW-1:0]        B_GNT_ID,
   output logic                 B_GNT_VALID,
   input  logic [SW-1:0]        B_SLV_ID,
   input  logic [N_SLAVES-1:0]  B_SBSY,
   output logic                 B_SPLIT
`ifdef BUS_ARB_TIMEOUT_EN
   ,
   output logic                 ARB_TOUT
`endif
);

   arb_state_t           state_q, state_d;
   logic [MW-1:0]        ptr_q, ptr_d;
   logic                 spl_vld_q, spl_vld_d;
   logic [MW-1:0]        spl_id_q, spl_id_d;
   logic [SW-1:0]        spl_slv_q, spl_slv_d;
   logic [N_MASTERS-1:0] gnt_q, gnt_d;
   logic [N_MASTERS-1:0] msplit_q, msplit_d;
   logic [MW-1:0]        gid_q, gid_d;
   logic                 gvld_q, gvld_d;

   logic [N_MASTERS-1:0] mask;
   logic [MW-1:0]        pick_id;
   logic                 pick_vld;
   logic                 owner_req;
   logic                 split_hit;
   logic                 abort;
   logic                 resume_ok;
   logic                 tmo;

   assign owner_req = M_BREQ[gid_q];
   assign split_hit = B_SBSY[B_SLV_ID];
   assign abort     = spl_vld_q & ~M_BREQ[spl_id_q];
   assign resume_ok = spl_vld_q & ~abort & ~B_SBSY[spl_slv_q];

   // The parked master never competes for the lent bus.
   always_comb begin
      mask           = '0;
      mask[spl_id_q] = spl_vld_q;
   end

   rr_pick #(
      .N (N_MASTERS),
      .W (MW)
   ) u_pick (
      .req_i   (M_BREQ),
      .mask_i  (mask),
      .ptr_i   (ptr_q),
      .idx_o   (pick_id),
      .valid_o (pick_vld)
   );

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] own_cnt;
   logic          own_st;
   logic          new_gnt;
   logic          tout_q;

   assign own_st  = (state_q == OWN) | (state_q == LEND);
   assign new_gnt = ~gvld_q & gvld_d;
   assign tmo     = own_cnt == CW'(TIMEOUT - 1);

   counter #(
      .WIDTH (CW)
   ) u_cnt (
      .clk_i (CLK),
      .rst_i (RST),
      .clr_i (new_gnt),
      .en_i  (own_st),
      .cnt_o (own_cnt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) tout_q <= 1'b0;
      else     tout_q <= own_st & owner_req & tmo;
   end

   assign ARB_TOUT = tout_q;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (resume_ok) begin
               state_d = RETURN;
            end else if (pick_vld) begin
               if (spl_vld_q & ~abort) state_d = LEND;
               else                    state_d = OWN;
            end
         end
         OWN: begin
            if (~owner_req | tmo | split_hit) state_d = IDLE;
         end
         LEND: begin
            if (~owner_req) begin
               if (resume_ok) state_d = RETURN;
               else           state_d = IDLE;
            end else if (tmo) begin
               state_d = IDLE;
            end else if (abort) begin
               state_d = OWN;
            end
         end
         RETURN: begin
            if (abort) state_d = IDLE;
            else       state_d = OWN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d     = gnt_q;
      gid_d     = gid_q;
      gvld_d    = gvld_q;
      ptr_d     = ptr_q;
      spl_vld_d = spl_vld_q;
      spl_id_d  = spl_id_q;
      spl_slv_d = spl_slv_q;
      msplit_d  = msplit_q;
      if (abort) begin
         spl_vld_d = 1'b0;
         spl_id_d  = '0;
         msplit_d  = '0;
      end
      unique case (state_q)
         IDLE: begin
            if (~resume_ok & pick_vld) begin
               gnt_d          = '0;
               gnt_d[pick_id] = 1'b1;
               gid_d          = pick_id;
               gvld_d         = 1'b1;
               if (pick_id == MW'(N_MASTERS - 1)) ptr_d = '0;
               else                               ptr_d = pick_id + 1'b1;
            end
         end
         OWN, LEND: begin
            if (~owner_req | tmo | (state_q == OWN & split_hit)) begin
               gnt_d  = '0;
               gid_d  = '0;
               gvld_d = 1'b0;
            end
            // Release and timeout take precedence over a split request.
            if (state_q == OWN & owner_req & ~tmo & split_hit) begin
               spl_vld_d       = 1'b1;
               spl_id_d        = gid_q;
               spl_slv_d       = B_SLV_ID;
               msplit_d        = '0;
               msplit_d[gid_q] = 1'b1;
            end
         end
         RETURN: begin
            if (~abort) begin
               gnt_d           = '0;
               gnt_d[spl_id_q] = 1'b1;
               gid_d           = spl_id_q;
               gvld_d          = 1'b1;
               spl_vld_d       = 1'b0;
               msplit_d        = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gnt_q     <= '0;
         gid_q     <= '0;
         gvld_q    <= 1'b0;
         ptr_q     <= '0;
         spl_vld_q <= 1'b0;
         spl_id_q  <= '0;
         spl_slv_q <= '0;
         msplit_q  <= '0;
      end else begin
         gnt_q     <= gnt_d;
         gid_q     <= gid_d;
         gvld_q    <= gvld_d;
         ptr_q     <= ptr_d;
         spl_vld_q <= spl_vld_d;
         spl_id_q  <= spl_id_d;
         spl_slv_q <= spl_slv_d;
         msplit_q  <= msplit_d;
      end
   end

   assign M_BGRANT    = gnt_q;
   assign M_SPLIT     = msplit_q;
   assign B_GNT_ID    = gid_q;
   assign B_GNT_VALID = gvld_q;
   assign B_SPLIT     = spl_vld_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Arbiter and split-transaction controller for the serial shared bus. It grants bus ownership among `N_MASTERS` requesters using round-robin order. When a slave signals busy (split), it parks the owning master, lends the bus to the other requesters, and returns the bus to the parked master once that slave is ready again. It sits between the master ports and the bus mux/decoder; its grant index drives the bus mux select.

## Interface
- `N_MASTERS`, default 2: number of requesting masters (≥2).
- `N_SLAVES`, default 3: number of slaves; width of the busy vector.
- `TIMEOUT`, default 64: maximum ownership cycles. Used only with `BUS_ARB_TIMEOUT_EN`.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `M_BREQ` in `N_MASTERS`: bus request. Held high for the whole transaction, including while split.
- `M_BGRANT` out `N_MASTERS`: one-hot grant, or all zero.
- `M_SPLIT` out `N_MASTERS`: one-hot; the master is parked by a split.
- `B_GNT_ID` out `$clog2(N_MASTERS)`: index of the granted master; bus mux select.
- `B_GNT_VALID` out 1: some master is granted.
- `B_SLV_ID` in `$clog2(N_SLAVES)`: slave addressed by the current owner, from the decoder.
- `B_SBSY` in `N_SLAVES`: per-slave split/busy request.
- `B_SPLIT` out 1: high while a split master is parked.
- `ARB_TOUT` out 1: one-cycle pulse on forced release. Exists only with the macro.

## Operation
- State machine: IDLE, OWN, LEND, RETURN.
- Round-robin pointer `ptr`:
  - Reset value is 0.
  - Search order is `ptr`, `ptr+1`, … mod `N_MASTERS`.
  - After granting master i, `ptr` becomes (i+1) mod `N_MASTERS`.
  - The parked split master is excluded from the search.
- IDLE:
  - If any eligible BREQ is high, grant the round-robin winner and go to OWN, or to LEND if a split is parked.
  - Otherwise stay in IDLE.
- OWN (no split parked):
  - Owner drops BREQ: clear the grant and go to IDLE.
  - Owner BREQ high and `B_SBSY[B_SLV_ID]`=1: latch `split_id`=owner and `split_slv`=`B_SLV_ID`. Set `M_SPLIT[owner]`=1 and `B_SPLIT`=1, clear the grant, go to IDLE.
- LEND (split parked, another master owns the bus):
  - `B_SBSY` from other slaves is ignored; nested splits are not supported.
  - Owner drops BREQ: clear the grant. Go to RETURN if `B_SBSY[split_slv]`=0, else go to IDLE.
- RETURN: grant `split_id`, clear `M_SPLIT` and `B_SPLIT`, go to OWN. Do not update `ptr`.
- IDLE with a split parked:
  - If `B_SBSY[split_slv]`=0, go to RETURN. This has priority over new requests.
  - Otherwise grant an eligible requester and go to LEND.
- The lent bus is never preempted. A resume waits for the lender to release.
- Split master drops BREQ while parked (abort): clear `split_id`, `M_SPLIT` and `B_SPLIT` on the next edge. There is no return.
- Simultaneous events:
  - Owner drops BREQ in the same cycle as `B_SBSY` rises: release wins and the split is ignored.
  - A request arriving in the release cycle is served from IDLE on the next cycle.

## Timing
- Reset values, applied immediately and asynchronously:
  - `M_BGRANT`=0, `M_SPLIT`=0, `B_GNT_ID`=0, `B_GNT_VALID`=0, `B_SPLIT`=0, `ARB_TOUT`=0.
  - `ptr`=0, state=IDLE, `split_id`=0, `split_slv`=0.
- All outputs are registered.
- Grant latency: BREQ sampled high in IDLE → grant visible at the next edge.
- Release: BREQ sampled low → grant cleared at the next edge. There is at least one idle cycle between owners.
- Split: `B_SBSY` sampled → `M_SPLIT` and `B_SPLIT` high and grant low at the next edge. A lender can be granted one cycle later at the earliest.
- Resume: the release by the lender, or `B_SBSY[split_slv]` low while in IDLE, leads to the split master's grant 2 edges later, via RETURN.
- Reset during LEND or RETURN drops every grant and discards the parked split.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - An ownership counter clears on each new grant and increments while in OWN or LEND.
  - When the count reaches `TIMEOUT`-1 with BREQ still high: clear the grant, pulse `ARB_TOUT` for one cycle, go to IDLE. A parked split is kept.
  - The force-released master is treated as a new requester.
- Not defined: no counter, no `ARB_TOUT` port, ownership is unbounded.

## Structure
- Shared package `bus_pkg` holds:
  - the `arb_state_t` enum (IDLE, OWN, LEND, RETURN);
  - default `N_MASTERS` and `N_SLAVES`;
  - the `$clog2`-derived index widths.
- Sub-module `rr_pick`: combinational round-robin search. Inputs are request vector, mask and `ptr`; outputs are index and valid.
- The timeout counter reuses the existing `counter` module (WIDTH = `$clog2(TIMEOUT)`).

## Test plan
- Single requester:
  - Stimulus: `M_BREQ`=01 at cycle 0 after reset, dropped at cycle 5.
  - Response: `M_BGRANT`=01 and `B_GNT_ID`=0 from cycle 1; grant 00 at cycle 6.
- Contention:
  - Stimulus: `M_BREQ`=11 held, each owner releases after 4 cycles.
  - Response: grants go M0 → M1 → M0, with one idle cycle between them.
- Split and lend:
  - Stimulus: M0 owns, `B_SLV_ID`=2, `B_SBSY`=100.
  - Response: next cycle `M_SPLIT`=01, `B_SPLIT`=1, grant 00; M1 granted the cycle after.
  - Stimulus: `B_SBSY[2]` falls while M1 owns.
  - Response: M0 is not granted until M1 drops BREQ; M0 is granted 2 cycles later and `B_SPLIT`=0.
- Split with no lender:
  - Stimulus: M0 split, `B_SBSY[2]` falls 3 cycles later.
  - Response: M0 regranted 2 cycles after the fall.
- Abort and reset:
  - Stimulus: M0 drops BREQ while parked.
  - Response: `B_SPLIT`=0 on the next edge.
  - Stimulus: `RST` pulse mid-LEND.
  - Response: all outputs are 0 immediately.
- Timeout:
  - Stimulus: `BUS_ARB_TIMEOUT_EN` with `TIMEOUT`=16; M0 holds BREQ and M1 requests.
  - Response: `ARB_TOUT` pulses once, M0's grant is dropped after 16 owned cycles, and M1 is granted next.
